frame_pair_streamer: RTL and testbench

Synthesizable AXI4-Stream source that reads image frames from word-addressed memory and emits them as (old, new) frame pairs for the LRF fusion datapath. For each frame index f it streams frame max(f−FRAME_LAG, 0), then frame f, with per-phase sideband and tlast per pair. It generalises the bench-only input controller to any word width, frame size, frame count and lag. It also adds memory-latency tolerance, bounded outstanding reads and full output backpressure.

---
 rtl/frame_pair_pkg.sv | 21 ++
 rtl/frame_pair_slot_buf.sv | 71 +++++++
 rtl/frame_pair_streamer.sv | 169 ++++++++++++++++
 tb/tb_frame_pair_streamer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pair_pkg.sv
// Shared types and constants for the frame-pair streamer.
// FSM state, phase encoding and tuser bit positions.
package frame_pair_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef enum logic {
        OLD = 1'b0,
        NEW = 1'b1
    } phase_t;

    localparam int unsigned TUSER_SOP   = 0;
    localparam int unsigned TUSER_PHASE = 1;
    // Slot tag layout: {tlast, tuser[1:0]}
    localparam int unsigned TAG_W       = 3;

endpackage

// File: rtl/frame_pair_slot_buf.sv
// Ring of slots with separate issue/response/read pointers, so reads can be
// launched ahead of their data and drained in order to the stream.
module frame_pair_slot_buf #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 3,
    localparam int unsigned IDX_W = $clog2(DEPTH),
    localparam int unsigned PTR_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic              pop,
    output logic [PTR_W-1:0]  allocated,
    output logic [PTR_W-1:0]  filled,
    output logic [DATA_W-1:0] head_data,
    output logic [TAG_W-1:0]  head_tag
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [PTR_W-1:0]  issue_ptr;
    logic [PTR_W-1:0]  resp_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              resp_accept;
    logic              head_valid;
    logic              pop_en;

    assign allocated  = issue_ptr - rd_ptr;
    assign filled     = resp_ptr - rd_ptr;
    assign head_valid = (filled != '0);
    // A response with nothing outstanding (e.g. after reset) has no slot.
    assign resp_accept = resp_valid && (resp_ptr != issue_ptr);
    assign pop_en      = pop && head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_ptr <= '0;
            resp_ptr  <= '0;
            rd_ptr    <= '0;
        end else begin
            if (alloc_en)
                issue_ptr <= issue_ptr + PTR_W'(1);
            if (resp_accept)
                resp_ptr <= resp_ptr + PTR_W'(1);
            if (pop_en)
                rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en)
            tag_mem[issue_ptr[IDX_W-1:0]] <= alloc_tag;
        if (resp_accept)
            data_mem[resp_ptr[IDX_W-1:0]] <= resp_data;
    end

    // Storage is not reset; gating keeps the idle outputs at zero.
    always_comb begin
        head_data = '0;
        head_tag  = '0;
        if (head_valid) begin
            head_data = data_mem[rd_ptr[IDX_W-1:0]];
            head_tag  = tag_mem[rd_ptr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/frame_pair_streamer.sv
// Streams (old, new) frame pairs from word-addressed memory onto AXI4-Stream.
// Define FRAME_PAIR_LOOP_EN for continuous lapping with a stop input.
module frame_pair_streamer
    import frame_pair_pkg::*;
#(
    parameter int unsigned DATA_W          = 128,
    parameter int unsigned BEATS_PER_FRAME = 16384,
    parameter int unsigned N_FRAMES        = 2,
    parameter int unsigned FRAME_LAG       = 1,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic              s_axis_aclk,
    input  logic              rst,
    input  logic              start,
`ifdef FRAME_PAIR_LOOP_EN
    input  logic              stop,
`endif
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [1:0]        m_axis_tuser
);

    localparam int unsigned FW    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam int unsigned BW    = $clog2(BEATS_PER_FRAME);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [FW-1:0]     frame_cnt;
    phase_t            phase;
    logic [BW-1:0]     beat_cnt;
    logic [PTR_W-1:0]  allocated;
    logic [PTR_W-1:0]  filled;
    logic              issue;
    logic              pop;
    logic              last_beat;
    logic              pair_end;
    logic              run_end;
    logic              done_w;
    logic [1:0]        issue_user;
    logic [TAG_W-1:0]  issue_tag;
    logic [TAG_W-1:0]  head_tag;
    logic [ADDR_W-1:0] frame_a;
    logic [ADDR_W-1:0] src_frame;
    logic [ADDR_W-1:0] issue_addr;

    assign issue     = (state == ISSUE) && (allocated < PTR_W'(FIFO_DEPTH));
    assign last_beat = (beat_cnt == BW'(BEATS_PER_FRAME - 1));
    assign pair_end  = issue && (phase == NEW) && last_beat;
    assign pop       = m_axis_tvalid && m_axis_tready;
    assign done_w    = (state == DRAIN) && pop && (allocated == PTR_W'(1));

`ifdef FRAME_PAIR_LOOP_EN
    logic stop_req;

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst)
            stop_req <= 1'b0;
        else if (state == IDLE)
            stop_req <= 1'b0;
        else if (stop)
            stop_req <= 1'b1;
    end

    assign run_end = pair_end && (stop_req || stop);
`else
    assign run_end = pair_end && (frame_cnt == FW'(N_FRAMES - 1));
`endif

    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = ISSUE;
            ISSUE:   if (run_end) state_nxt = DRAIN;
            DRAIN:   if (done_w)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat, then phase, then frame; frame wraps so a looping run restarts at 0.
    always_ff @(posedge s_axis_aclk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            phase     <= OLD;
            beat_cnt  <= '0;
        end else if (state == IDLE) begin
            frame_cnt <= '0;
            phase     <= OLD;
            beat_cnt  <= '0;
        end else if (issue) begin
            if (!last_beat) begin
                beat_cnt <= beat_cnt + BW'(1);
            end else begin
                beat_cnt <= '0;
                if (phase == OLD) begin
                    phase <= NEW;
                end else begin
                    phase <= OLD;
                    if (frame_cnt == FW'(N_FRAMES - 1))
                        frame_cnt <= '0;
                    else
                        frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    always_comb begin
        frame_a = ADDR_W'(frame_cnt);
        if (phase == NEW)
            src_frame = frame_a;
        else if (frame_a >= ADDR_W'(FRAME_LAG))
            src_frame = frame_a - ADDR_W'(FRAME_LAG);
        else
            src_frame = '0;
        issue_addr = ADDR_W'(BASE_ADDR) + src_frame * ADDR_W'(BEATS_PER_FRAME)
                   + ADDR_W'(beat_cnt);
        issue_user              = '0;
        issue_user[TUSER_SOP]   = (beat_cnt == '0);
        issue_user[TUSER_PHASE] = phase;
        issue_tag = {(phase == NEW) && last_beat, issue_user};
    end

    always_comb begin
        busy        = (state != IDLE);
        done        = done_w;
        mem_rd_en   = issue;
        mem_rd_addr = issue ? issue_addr : '0;
    end

    frame_pair_slot_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .TAG_W  (TAG_W)
    ) u_slot_buf (
        .clk        (s_axis_aclk),
        .rst        (rst),
        .alloc_en   (issue),
        .alloc_tag  (issue_tag),
        .resp_valid (mem_rd_valid),
        .resp_data  (mem_rd_data),
        .pop        (pop),
        .allocated  (allocated),
        .filled     (filled),
        .head_data  (m_axis_tdata),
        .head_tag   (head_tag)
    );

    assign m_axis_tvalid = (filled != '0);
    assign {m_axis_tlast, m_axis_tuser} = head_tag;

endmodule

// File: tb/tb_frame_pair_streamer.sv
// Directed scoreboard bench for frame_pair_streamer (B=4, N=3, lag 1, depth 4).
// Memory model returns data = address with fixed or random in-order latency.
module tb_frame_pair_streamer;

    localparam int DW  = 32;
    localparam int BPF = 4;
    localparam int NF  = 3;
    localparam int LAG = 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [31:0]   mem_rd_addr;
    logic          mem_rd_valid;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [1:0]    m_axis_tuser;
`ifdef FRAME_PAIR_LOOP_EN
    logic          stop;
    int unsigned   stop_at = 17;
`endif

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    req_t        mq[$];
    logic [34:0] sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned rd_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned d0;
    int          rmode = 1;
    bit          rand_lat = 0;
    bit          hold_v = 0;
    bit          tv_seen;
    logic [34:0] hold_val;

    frame_pair_streamer #(
        .DATA_W          (DW),
        .BEATS_PER_FRAME (BPF),
        .N_FRAMES        (NF),
        .FRAME_LAG       (LAG),
        .ADDR_W          (32),
        .BASE_ADDR       (0),
        .FIFO_DEPTH      (4)
    ) dut (
        .s_axis_aclk   (clk),
        .rst           (rst),
        .start         (start),
`ifdef FRAME_PAIR_LOOP_EN
        .stop          (stop),
`endif
        .busy          (busy),
        .done          (done),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_valid  (mem_rd_valid),
        .mem_rd_data   (mem_rd_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden pairs: old = max(f-LAG,0), new = f; data equals word address.
    task automatic push_pairs(input int n_pairs);
        int f;
        int src;
        for (int k = 0; k < n_pairs; k++) begin
            f = k % NF;
            for (int ph = 0; ph < 2; ph++) begin
                src = (ph == 1) ? f : ((f >= LAG) ? f - LAG : 0);
                for (int b = 0; b < BPF; b++)
                    sb.push_back({1'((ph == 1) && (b == BPF - 1)), 1'(ph), 1'(b == 0),
                                  32'(src * BPF + b)});
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic start_run();
        @(negedge clk) rd_cnt = 0;
        pulse_start();
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        @(negedge clk);
        check({tag, " busy after done"}, 64'(busy), 64'd0);
        check({tag, " scoreboard left"}, 64'(sb.size()), 64'd0);
    endtask

    // Memory model: request seen at negedge n is answered at negedge n+latency.
    always @(negedge clk) begin
        cyc++;
        if (mem_rd_en) begin
            rd_cnt++;
            mq.push_back('{addr: mem_rd_addr,
                           due: cyc + (rand_lat ? $urandom_range(1, 5) : 2)});
        end
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mq[0].addr;
            void'(mq.pop_front());
        end else begin
            mem_rd_valid = 1'b0;
            mem_rd_data  = '0;
        end
    end

    // Sink: drive tready, check stability under backpressure, score accepted beats.
    always @(negedge clk) begin
        case (rmode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (hold_v && m_axis_tvalid)
            check("held beat stable", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                  64'(hold_val));
        hold_v   = m_axis_tvalid && !m_axis_tready;
        hold_val = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0)
                check("unexpected beat", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                      64'h1_0000_0000_0000);
            else
                check("beat", 64'({m_axis_tlast, m_axis_tuser, m_axis_tdata}),
                      64'(sb.pop_front()));
        end
        if (done) done_cnt++;
    end

`ifdef FRAME_PAIR_LOOP_EN
    always @(negedge clk)
        stop = busy && (rd_cnt >= stop_at);
`endif

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mem_rd_valid = 1'b0;
        mem_rd_data = '0;
        m_axis_tready = 1'b0;
`ifdef FRAME_PAIR_LOOP_EN
        stop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset rd_en", 64'(mem_rd_en), 64'd0);
        check("reset rd_addr", 64'(mem_rd_addr), 64'd0);
        check("reset tvalid", 64'(m_axis_tvalid), 64'd0);
        check("reset tlast", 64'(m_axis_tlast), 64'd0);
        check("reset tuser", 64'(m_axis_tuser), 64'd0);
        check("reset tdata", 64'(m_axis_tdata), 64'd0);
        rst = 1'b0;

        // Basic run with first-issue and first-valid latency
        d0 = done_cnt;
        push_pairs(NF);
        start_run();
        check("first rd_en", 64'(mem_rd_en), 64'd1);
        check("first rd_addr", 64'(mem_rd_addr), 64'd0);
        check("busy after start", 64'(busy), 64'd1);
        repeat (2) @(negedge clk);
        check("tvalid before latency", 64'(m_axis_tvalid), 64'd0);
        @(negedge clk);
        check("tvalid at latency", 64'(m_axis_tvalid), 64'd1);
        wait_done(200, "basic");
        repeat (4) @(negedge clk);
        check("basic done count", 64'(done_cnt - d0), 64'd1);

        // Full backpressure: only FIFO_DEPTH reads may be issued
        rmode = 0;
        push_pairs(NF);
        start_run();
        repeat (20) @(negedge clk);
        check("hold rd_en count", 64'(rd_cnt), 64'd4);
        check("hold tvalid", 64'(m_axis_tvalid), 64'd1);
        check("hold tdata", 64'(m_axis_tdata), 64'd0);
        rmode = 1;
        wait_done(200, "hold");

        // Random tready and random memory latency
        rmode = 2;
        rand_lat = 1;
        push_pairs(NF);
        start_run();
        wait_done(2000, "random");
        rand_lat = 0;
        rmode = 1;
        repeat (8) @(negedge clk);

        // Start re-pulsed mid-run is ignored
        d0 = done_cnt;
        push_pairs(NF);
        start_run();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_done(200, "restart");
        repeat (4) @(negedge clk);
        check("restart done count", 64'(done_cnt - d0), 64'd1);

        // Reset during pair 2 with reads in flight
        push_pairs(NF);
        start_run();
        for (int i = 0; i < 100 && rd_cnt < 10; i++) @(negedge clk);
        check("reached pair 2", 64'(rd_cnt >= 10), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst ctrl", 64'({busy, done, mem_rd_en, m_axis_tvalid, m_axis_tlast,
                                  m_axis_tuser}), 64'd0);
        check("midrst rd_addr", 64'(mem_rd_addr), 64'd0);
        check("midrst tdata", 64'(m_axis_tdata), 64'd0);
        @(negedge clk) rst = 1'b0;
        sb.delete();
        tv_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_axis_tvalid) tv_seen = 1;
        end
        check("late responses dropped", 64'(tv_seen), 64'd0);
        d0 = done_cnt;
        push_pairs(NF);
        start_run();
        wait_done(200, "post reset");
        repeat (4) @(negedge clk);
        check("post reset done count", 64'(done_cnt - d0), 64'd1);

`ifdef FRAME_PAIR_LOOP_EN
        // Stop during pair 2 of lap 2: run ends after that pair's tlast
        stop_at = 35;
        d0 = done_cnt;
        push_pairs(NF + 2);
        start_run();
        wait_done(400, "loop stop");
        repeat (4) @(negedge clk);
        check("loop done count", 64'(done_cnt - d0), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1);
    end

endmodule
